hazard_mdu: RTL and testbench

Parametrised next-generation hazard unit for the 5-stage pipelined MIPS core. Provides:
- D- and E-stage forwarding selects.
- Load-use and branch-compare stalls, with register-0 and regwrite qualification fixed.
- A sequential tracker for a multi-cycle mult/div unit (MDU) that stalls HI/LO readers and back-to-back MDU ops.
- A saturating stall-cycle counter for performance monitoring.

Sits beside the datapath and drives the F/D pipeline-register enables and the E flush.

---
 rtl/hazard_mdu_pkg.sv | 18 +
 rtl/hazard_mdu_if.sv | 55 +++++
 rtl/hazard_mdu_tracker.sv | 64 ++++++
 rtl/hazard_mdu.sv | 88 ++++++++
 tb/tb_hazard_mdu.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_mdu_pkg.sv
// Shared types for the hazard unit: forwarding selects, MDU tracker states
// and the hard-wired-zero register index.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_mdu_if.sv
// Datapath <-> hazard unit bundle; master is the datapath side, slave is the
// hazard unit (register ids and enables in, forwarding/stall/MDU status out).
interface hazard_mdu_if
  import hazard_pkg::*;
#(
  parameter int REGW = 5,
  parameter int CNTW = 32
) ();

  logic [REGW-1:0] rsD;
  logic [REGW-1:0] rtD;
  logic [REGW-1:0] rsE;
  logic [REGW-1:0] rtE;
  logic [REGW-1:0] writeregE;
  logic [REGW-1:0] writeregM;
  logic [REGW-1:0] writeregW;
  logic            regwriteE;
  logic            regwriteM;
  logic            regwriteW;
  logic            memtoregE;
  logic            memtoregM;
  logic            branchD;
  logic            mdustartD;
  logic            mdustartE;
  logic            hiloreadD;

  logic            forwardaD;
  logic            forwardbD;
  fwd_sel_t        forwardaE;
  fwd_sel_t        forwardbE;
  logic            stallF;
  logic            stallD;
  logic            flushE;
  logic            mdu_go;
  logic            mdu_busy;
  logic            mdu_done;
  logic [CNTW-1:0] stall_cycles;

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    output regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
    output branchD, mdustartD, mdustartE, hiloreadD,
    input  forwardaD, forwardbD, forwardaE, forwardbE,
    input  stallF, stallD, flushE, mdu_go, mdu_busy, mdu_done, stall_cycles
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    input  regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
    input  branchD, mdustartD, mdustartE, hiloreadD,
    output forwardaD, forwardbD, forwardaE, forwardbE,
    output stallF, stallD, flushE, mdu_go, mdu_busy, mdu_done, stall_cycles
  );

endinterface

// File: rtl/hazard_mdu_tracker.sv
// Tracks one in-flight mult/div op: go is combinational on the start cycle,
// busy/done are registered and cover the following MDU_LAT-1 cycles.
module mdu_tracker
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic go,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(MDU_LAT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MDU_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);

  mdu_state_t    state;
  logic [CW-1:0] cnt;

  // A start while already busy is dropped: D is stalled so it should not occur.
  assign go = (state == MDU_IDLE) && start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MDU_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (start) begin
            state <= MDU_BUSY;
            cnt   <= CNT_LAST;
            busy  <= 1'b1;
            done  <= (CNT_LAST == CNT_ONE);
          end
        end
        MDU_BUSY: begin
          if (cnt == CNT_ONE) begin
            state <= MDU_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else begin
            cnt  <= cnt - CNT_ONE;
            done <= (cnt == CNT_TWO);
          end
        end
        default: begin
          state <= MDU_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_mdu.sv
// Hazard unit for the 5-stage MIPS pipe: combinational forwarding and stall
// decisions, MDU occupancy tracking and a saturating stall-cycle counter.
module hazard_mdu
  import hazard_pkg::*;
#(
  parameter int REGW    = 5,
  parameter int MDU_LAT = 8,
  parameter int CNTW    = 32
) (
  input  logic         clk,
  input  logic         reset,
  hazard_mdu_if.slave  bus
);

  localparam logic [REGW-1:0] ZERO = REGW'(REG_ZERO);

  fwd_sel_t        fwd_a;
  fwd_sel_t        fwd_b;
  logic            lwstall;
  logic            branchstall;
  logic            mdustall;
  logic            stall;
  logic            go;
  logic            busy;
  logic            done;
  logic [CNTW-1:0] stall_cnt;

  assign bus.forwardaD = (bus.rsD != ZERO) && bus.regwriteM && (bus.rsD == bus.writeregM);
  assign bus.forwardbD = (bus.rtD != ZERO) && bus.regwriteM && (bus.rtD == bus.writeregM);

  // M is the younger result, so it wins over W.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if ((bus.rsE != ZERO) && bus.regwriteM && (bus.rsE == bus.writeregM))
      fwd_a = FWD_MEM;
    else if ((bus.rsE != ZERO) && bus.regwriteW && (bus.rsE == bus.writeregW))
      fwd_a = FWD_WB;
    if ((bus.rtE != ZERO) && bus.regwriteM && (bus.rtE == bus.writeregM))
      fwd_b = FWD_MEM;
    else if ((bus.rtE != ZERO) && bus.regwriteW && (bus.rtE == bus.writeregW))
      fwd_b = FWD_WB;
  end

  assign bus.forwardaE = fwd_a;
  assign bus.forwardbE = fwd_b;

  assign lwstall = bus.memtoregE && bus.regwriteE && (bus.writeregE != ZERO) &&
                   ((bus.writeregE == bus.rsD) || (bus.writeregE == bus.rtD));

  assign branchstall = bus.branchD &&
      ((bus.regwriteE && (bus.writeregE != ZERO) &&
        ((bus.writeregE == bus.rsD) || (bus.writeregE == bus.rtD))) ||
       (bus.memtoregM && (bus.writeregM != ZERO) &&
        ((bus.writeregM == bus.rsD) || (bus.writeregM == bus.rtD))));

  mdu_tracker #(.MDU_LAT(MDU_LAT)) u_tracker (
    .clk   (clk),
    .reset (reset),
    .start (bus.mdustartE),
    .go    (go),
    .busy  (busy),
    .done  (done)
  );

  // Results are readable in the done cycle, so a HI/LO reader may proceed then.
  assign mdustall = (bus.hiloreadD || bus.mdustartD) &&
                    ((busy && !done) || bus.mdustartE);

  assign stall      = lwstall || branchstall || mdustall;
  assign bus.stallD = stall;
  assign bus.stallF = stall;
  assign bus.flushE = stall;

  assign bus.mdu_go   = go;
  assign bus.mdu_busy = busy;
  assign bus.mdu_done = done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNTW'(1);
  end

  assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_mdu.sv
// Directed bench: combinational vector table plus load-use, branch, MDU,
// mid-op reset and counter saturation sequences.
module tb_hazard_mdu;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_mdu_if #(.REGW(5), .CNTW(4)) bus ();

  hazard_mdu #(.REGW(5), .MDU_LAT(8), .CNTW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // regs: rsD rtD rsE rtE wE wM wW
  // flags: {regwriteE,regwriteM,regwriteW,memtoregE,memtoregM,branchD,mdustartD,mdustartE,hiloreadD}
  // exp:   {forwardaD,forwardbD,forwardaE[1:0],forwardbE[1:0],stallD}
  typedef struct {
    logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
    logic [8:0] flags;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.rsD       = v.rsD;
    bus.rtD       = v.rtD;
    bus.rsE       = v.rsE;
    bus.rtE       = v.rtE;
    bus.writeregE = v.wE;
    bus.writeregM = v.wM;
    bus.writeregW = v.wW;
    {bus.regwriteE, bus.regwriteM, bus.regwriteW, bus.memtoregE, bus.memtoregM,
     bus.branchD, bus.mdustartD, bus.mdustartE, bus.hiloreadD} = v.flags;
  endtask

  task automatic clear();
    vec_t z;
    z = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 9'b0, 7'b0};
    drive(z);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t lu;
    int busy_n;
    int done_n;

    vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 9'b000000000, 7'b0000000};
    vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 9'b011000000, 7'b0010000};
    vecs[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 9'b001000000, 7'b0001000};
    vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 9'b011000000, 7'b0000000};
    vecs[4]  = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd7, 5'd0, 9'b010000000, 7'b0000100};
    vecs[5]  = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd7, 5'd7, 9'b001000000, 7'b0000010};
    vecs[6]  = '{5'd4, 5'd9, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 9'b010000000, 7'b1000000};
    vecs[7]  = '{5'd0, 5'd6, 5'd6, 5'd0, 5'd0, 5'd6, 5'd0, 9'b010000000, 7'b0110000};
    vecs[8]  = '{5'd0, 5'd8, 5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 9'b100100000, 7'b0000001};
    vecs[9]  = '{5'd0, 5'd8, 5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 9'b000100000, 7'b0000000};
    vecs[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 9'b100100000, 7'b0000000};
    vecs[11] = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 9'b100001000, 7'b0000001};
    vecs[12] = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 9'b000011000, 7'b0000001};
    vecs[13] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 9'b100001000, 7'b0000000};
    vecs[14] = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 9'b100000000, 7'b0000000};
    vecs[15] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 9'b000000110, 7'b0000001};
    vecs[16] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 9'b000000001, 7'b0000000};
    vecs[17] = '{5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 9'b010001000, 7'b0100000};
    lu       = '{5'd0, 5'd8, 5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 9'b100100000, 7'b0000001};

    clear();
    #2;
    chk("reset_busy", 32'(bus.mdu_busy), 32'd0);
    chk("reset_done", 32'(bus.mdu_done), 32'd0);
    chk("reset_go", 32'(bus.mdu_go), 32'd0);
    chk("reset_cnt", 32'(bus.stall_cycles), 32'd0);

    // Combinational table, applied while held in reset (tracker IDLE).
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d_out", i),
          32'({bus.forwardaD, bus.forwardbD, bus.forwardaE, bus.forwardbE, bus.stallD}),
          32'(vecs[i].exp));
      chk($sformatf("vec%0d_stallF", i), 32'(bus.stallF), 32'(vecs[i].exp[0]));
      chk($sformatf("vec%0d_flushE", i), 32'(bus.flushE), 32'(vecs[i].exp[0]));
    end
    clear();
    tick();
    reset = 1'b0;

    // Load-use: one stalled cycle
    drive(lu);
    #1;
    chk("lu_stallD", 32'(bus.stallD), 32'd1);
    chk("lu_cnt0", 32'(bus.stall_cycles), 32'd0);
    tick();
    clear();
    #1;
    chk("lu_release", 32'(bus.stallD), 32'd0);
    chk("lu_cnt1", 32'(bus.stall_cycles), 32'd1);
    tick();
    chk("lu_cnt_hold", 32'(bus.stall_cycles), 32'd1);

    // Branch compare: producer in E, then load in M
    bus.branchD = 1'b1; bus.regwriteE = 1'b1; bus.writeregE = 5'd3; bus.rsD = 5'd3;
    #1;
    chk("br_e_stall", 32'(bus.stallD), 32'd1);
    tick();
    bus.regwriteE = 1'b0; bus.writeregE = 5'd0; bus.memtoregM = 1'b1; bus.writeregM = 5'd3;
    #1;
    chk("br_m_stall", 32'(bus.stallD), 32'd1);
    tick();
    clear();
    #1;
    chk("br_release", 32'(bus.stallD), 32'd0);
    chk("br_cnt", 32'(bus.stall_cycles), 32'd3);

    // MDU op with an mfhi waiting in D
    reset = 1'b1;
    #1;
    chk("rst_cnt_clear", 32'(bus.stall_cycles), 32'd0);
    reset = 1'b0;
    tick();
    bus.mdustartE = 1'b1; bus.hiloreadD = 1'b1;
    #1;
    chk("mdu_c0_go", 32'(bus.mdu_go), 32'd1);
    chk("mdu_c0_stall", 32'(bus.stallD), 32'd1);
    chk("mdu_c0_busy", 32'(bus.mdu_busy), 32'd0);
    tick();
    bus.mdustartE = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      #1;
      chk($sformatf("mdu_c%0d_busy", c), 32'(bus.mdu_busy), 32'd1);
      chk($sformatf("mdu_c%0d_done", c), 32'(bus.mdu_done), (c == 7) ? 32'd1 : 32'd0);
      chk($sformatf("mdu_c%0d_stall", c), 32'(bus.stallD), (c == 7) ? 32'd0 : 32'd1);
      chk($sformatf("mdu_c%0d_go", c), 32'(bus.mdu_go), 32'd0);
      tick();
    end
    #1;
    chk("mdu_c8_busy", 32'(bus.mdu_busy), 32'd0);
    chk("mdu_c8_done", 32'(bus.mdu_done), 32'd0);
    chk("mdu_c8_stall", 32'(bus.stallD), 32'd0);
    chk("mdu_cnt", 32'(bus.stall_cycles), 32'd7);
    clear();
    tick();

    // Reset in the middle of an op, then a fresh full op
    bus.mdustartE = 1'b1;
    tick();
    bus.mdustartE = 1'b0;
    tick();
    tick();
    chk("mid_busy_pre", 32'(bus.mdu_busy), 32'd1);
    chk("mid_cnt_pre", 32'(bus.stall_cycles), 32'd7);
    reset = 1'b1;
    #1;
    chk("mid_busy_rst", 32'(bus.mdu_busy), 32'd0);
    chk("mid_cnt_rst", 32'(bus.stall_cycles), 32'd0);
    chk("mid_done_rst", 32'(bus.mdu_done), 32'd0);
    tick();
    reset = 1'b0;
    bus.mdustartE = 1'b1;
    #1;
    chk("re_go", 32'(bus.mdu_go), 32'd1);
    tick();
    bus.mdustartE = 1'b0;
    busy_n = 0;
    done_n = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.mdu_busy) busy_n++;
      if (bus.mdu_done) done_n++;
      tick();
    end
    chk("re_busy_cycles", 32'(busy_n), 32'd7);
    chk("re_done_pulses", 32'(done_n), 32'd1);

    // Counter saturation at 4 bits
    reset = 1'b1;
    #1;
    reset = 1'b0;
    drive(lu);
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("sat_%0d", i), 32'(bus.stall_cycles), (i > 15) ? 32'd15 : 32'(i));
    end
    clear();
    tick();
    chk("sat_hold", 32'(bus.stall_cycles), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
